// File: rtl/img_readout_chunker_pkg.sv
// -----------------------------------------------------------------------------
// img_readout_chunker_pkg
// Shared constants and types for the readout chunker slice.
//   DefaultChunkWords    16-bit words per chunk (one 512-byte SD block)
//   DefaultMaxWordCount  largest stream length the word counters must hold
//   reg_width()          bits needed to hold a value 0..v
//   wr_state_t           write-side FSM states
// -----------------------------------------------------------------------------
package img_readout_chunker_pkg;

  localparam int DefaultChunkWords   = 256;
  localparam int DefaultMaxWordCount = 1 << 22;

  // Width of a register that must count from 0 up to and including value.
  function automatic int reg_width(input longint value);
    return $clog2(value + 1);
  endfunction

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FILL,
    WR_DONE_WAIT
  } wr_state_t;

endpackage

// File: rtl/img_chunk_ram.sv
// -----------------------------------------------------------------------------
// img_chunk_ram
// Simple dual-port RAM backing both halves of the ping-pong chunk buffer.
//   clk    single clock
//   we     write enable
//   waddr  write address {buffer, index}
//   wdata  write data
//   raddr  read address {buffer, index}, sampled every cycle
//   rdata  registered read data (one-cycle latency)
// -----------------------------------------------------------------------------
module img_chunk_ram #(
  parameter int Depth = 512,
  parameter int DataW = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [DataW-1:0]         wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [DataW-1:0]         rdata
);

  logic [DataW-1:0] mem [Depth];

  // Write-first behaviour on an address collision: a one-word chunk is
  // committed on the same edge its only word is written, and the reader
  // prefetches that word on that very edge, so it must see the new value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/img_readout_chunker.sv
// -----------------------------------------------------------------------------
// img_readout_chunker
// Repacks the ImgController readout word stream into fixed-size chunks held in
// a ping-pong buffer. A chunk is handed to the SD-write side only when it is
// full or is the final partial chunk of the stream.
// Optional feature macro: IMG_CHUNK_SUM_EN (running 32-bit sum of input words).
// Ports:
//   clk              single clock
//   rst              synchronous active-high reset
//   cmd_start        one-cycle pulse starting a stream, latches cmd_wordCount
//   cmd_wordCount    number of words in the stream
//   readout_ready    upstream word valid
//   readout_trigger  upstream word accepted when ready && trigger
//   readout_data     upstream word
//   chunk_ready      output word valid
//   chunk_trigger    consumer accepts the word when ready && trigger
//   chunk_data       output word
//   chunk_last       marks the final word of each chunk
//   chunk_len        word count of the chunk being drained (0 when idle)
//   status_done      toggles once the final chunk has drained
//   status_sum       running word sum (0 without IMG_CHUNK_SUM_EN)
// -----------------------------------------------------------------------------
module img_readout_chunker
  import img_readout_chunker_pkg::*;
#(
  parameter int ChunkWords   = DefaultChunkWords,
  parameter int MaxWordCount = DefaultMaxWordCount
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_start,
  input  logic [reg_width(MaxWordCount)-1:0]  cmd_wordCount,
  input  logic                                readout_ready,
  output logic                                readout_trigger,
  input  logic [15:0]                         readout_data,
  output logic                                chunk_ready,
  input  logic                                chunk_trigger,
  output logic [15:0]                         chunk_data,
  output logic                                chunk_last,
  output logic [$clog2(ChunkWords):0]         chunk_len,
  output logic                                status_done,
  output logic [31:0]                         status_sum
);

  localparam int CountW = reg_width(MaxWordCount);
  localparam int IdxW   = $clog2(ChunkWords);
  localparam int LenW   = IdxW + 1;

  wr_state_t         wr_state;
  logic [CountW-1:0] remaining;
  logic              wr_buf;
  logic [IdxW-1:0]   wr_idx;
  logic              rd_buf;
  logic [IdxW-1:0]   rd_idx;
  logic              rd_buf_next;
  logic [IdxW-1:0]   rd_idx_next;
  logic [1:0]        buf_full;
  logic [LenW-1:0]   buf_len [2];
  logic [LenW-1:0]   rd_len;
  logic              rd_is_last;
  logic              in_accept;
  logic              wr_commit;
  logic              out_accept;
  logic              rd_release;

  // Upstream is only triggered while filling into an empty buffer; a full
  // write buffer stalls the source instead of dropping words.
  assign readout_trigger = (wr_state == WR_FILL) && !buf_full[wr_buf];
  assign in_accept       = readout_ready && readout_trigger;
  assign wr_commit       = in_accept &&
                           ((wr_idx == IdxW'(ChunkWords - 1)) || (remaining == CountW'(1)));

  assign rd_len      = buf_len[rd_buf];
  assign rd_is_last  = ((LenW'(rd_idx) + LenW'(1)) == rd_len);
  assign chunk_ready = buf_full[rd_buf];
  assign chunk_last  = chunk_ready && rd_is_last;
  assign chunk_len   = chunk_ready ? rd_len : '0;
  assign out_accept  = chunk_ready && chunk_trigger;
  assign rd_release  = out_accept && rd_is_last;

  // Next read position. The RAM is addressed with this value so that the word
  // at the upcoming position is already on chunk_data when the edge lands,
  // giving zero-bubble draining and valid data the cycle chunk_ready rises.
  always_comb begin
    rd_buf_next = rd_buf;
    rd_idx_next = rd_idx;
    if (out_accept) begin
      if (rd_is_last) begin
        rd_buf_next = ~rd_buf;
        rd_idx_next = '0;
      end else begin
        rd_idx_next = rd_idx + IdxW'(1);
      end
    end
  end

  // Write FSM, read pointers and buffer bookkeeping. A commit always targets
  // an empty buffer and a release always targets a full one, so both may
  // update buf_full in the same cycle without touching the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state    <= WR_IDLE;
      remaining   <= '0;
      wr_buf      <= 1'b0;
      wr_idx      <= '0;
      rd_buf      <= 1'b0;
      rd_idx      <= '0;
      buf_full    <= 2'b00;
      buf_len[0]  <= '0;
      buf_len[1]  <= '0;
      status_done <= 1'b0;
    end else begin
      rd_buf <= rd_buf_next;
      rd_idx <= rd_idx_next;
      if (rd_release) begin
        buf_full[rd_buf] <= 1'b0;
      end

      case (wr_state)
        WR_IDLE: begin
          if (cmd_start) begin
            remaining <= cmd_wordCount;
            wr_idx    <= '0;
            wr_state  <= (cmd_wordCount == '0) ? WR_DONE_WAIT : WR_FILL;
          end
        end

        WR_FILL: begin
          if (in_accept) begin
            remaining <= remaining - CountW'(1);
            if (wr_commit) begin
              buf_full[wr_buf] <= 1'b1;
              buf_len[wr_buf]  <= LenW'(wr_idx) + LenW'(1);
              wr_buf           <= ~wr_buf;
              wr_idx           <= '0;
              if (remaining == CountW'(1)) begin
                wr_state <= WR_DONE_WAIT;
              end
            end else begin
              wr_idx <= wr_idx + IdxW'(1);
            end
          end
        end

        WR_DONE_WAIT: begin
          if (buf_full == 2'b00) begin
            wr_state    <= WR_IDLE;
            status_done <= ~status_done;
          end
        end

        default: wr_state <= WR_IDLE;
      endcase
    end
  end

`ifdef IMG_CHUNK_SUM_EN
  // Running checksum of every accepted input word; restarts with each stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_sum <= '0;
    end else if ((wr_state == WR_IDLE) && cmd_start) begin
      status_sum <= '0;
    end else if (in_accept) begin
      status_sum <= status_sum + {16'h0000, readout_data};
    end
  end
`else
  assign status_sum = '0;
`endif

  img_chunk_ram #(
    .Depth (2 * ChunkWords),
    .DataW (16)
  ) u_ram (
    .clk   (clk),
    .we    (in_accept),
    .waddr ({wr_buf, wr_idx}),
    .wdata (readout_data),
    .raddr ({rd_buf_next, rd_idx_next}),
    .rdata (chunk_data)
  );

endmodule

// File: tb/tb_img_readout_chunker.sv
// -----------------------------------------------------------------------------
// tb_img_readout_chunker
// Self-checking bench for img_readout_chunker. A reference model keeps the
// accepted words in a queue and derives chunk boundaries, lengths and the
// word sum arithmetically from the stream length.
// -----------------------------------------------------------------------------
module tb_img_readout_chunker;

  localparam int ChunkWords = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [22:0] cmd_wordCount;
  logic        readout_ready;
  logic        readout_trigger;
  logic [15:0] readout_data;
  logic        chunk_ready;
  logic        chunk_trigger;
  logic [15:0] chunk_data;
  logic        chunk_last;
  logic [8:0]  chunk_len;
  logic        status_done;
  logic [31:0] status_sum;

  int checks   = 0;
  int failures = 0;

  logic [15:0] in_q[$];
  logic [15:0] exp_q[$];
  logic [31:0] model_sum;

  img_readout_chunker dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_start       (cmd_start),
    .cmd_wordCount   (cmd_wordCount),
    .readout_ready   (readout_ready),
    .readout_trigger (readout_trigger),
    .readout_data    (readout_data),
    .chunk_ready     (chunk_ready),
    .chunk_trigger   (chunk_trigger),
    .chunk_data      (chunk_data),
    .chunk_last      (chunk_last),
    .chunk_len       (chunk_len),
    .status_done     (status_done),
    .status_sum      (status_sum)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one stream of n words. mode: 0 = 1,2,3..  1 = 0x0FFF descending
  // 2 = random. ready_pct/trig_pct set handshake probabilities, hold keeps
  // chunk_trigger low for that many cycles, abort_at > 0 leaves the stream
  // early once that many words went in, glitch pulses a stray cmd_start.
  task automatic applyStimulus(input int n, input int mode, input int ready_pct,
                               input int trig_pct, input int hold,
                               input int abort_at, input bit glitch);
    int   sent = 0;
    int   got = 0;
    int   cyc = 0;
    int   exp_len;
    bit   done_seen = 1'b0;
    logic done_before;

    in_q.delete();
    exp_q.delete();
    model_sum = 32'd0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       in_q.push_back(16'(i + 1));
        1:       in_q.push_back(16'(32'h0FFF - i));
        default: in_q.push_back(16'($urandom));
      endcase
    end

    @(negedge clk);
    done_before   = status_done;
    cmd_start     = 1'b1;
    cmd_wordCount = 23'(n);
    readout_ready = 1'b0;
    chunk_trigger = 1'b0;

    while (cyc < 20000) begin
      @(negedge clk);
      if (status_done !== done_before) begin
        done_seen = 1'b1;
        break;
      end
      cyc++;
      cmd_start     = glitch && (cyc == 5);
      cmd_wordCount = (glitch && (cyc == 5)) ? 23'd3 : 23'(n);
      readout_ready = (sent < n) && ($urandom_range(99) < ready_pct);
      readout_data  = readout_ready ? in_q[sent] : 16'($urandom);
      chunk_trigger = (cyc > hold) && ($urandom_range(99) < trig_pct);

      if (sent >= n) checkOutput("trigger_after_count", {31'd0, readout_trigger}, 32'd0);

      if (readout_ready && readout_trigger) begin
        exp_q.push_back(in_q[sent]);
        model_sum += {16'd0, in_q[sent]};
        sent++;
      end

      if (chunk_ready && chunk_trigger) begin
        exp_len = n - (got / ChunkWords) * ChunkWords;
        if (exp_len > ChunkWords) exp_len = ChunkWords;
        if (exp_q.size() == 0) checkOutput("unexpected_word", 32'd1, 32'd0);
        else checkOutput("chunk_data", {16'd0, chunk_data}, {16'd0, exp_q.pop_front()});
        checkOutput("chunk_len", {23'd0, chunk_len}, exp_len);
        checkOutput("chunk_last", {31'd0, chunk_last}, {31'd0, ((got % ChunkWords) == exp_len - 1)});
        got++;
      end

      if ((hold > 0) && (cyc == hold))
        checkOutput("backpressure_accepted", sent, (n < 2 * ChunkWords) ? n : 2 * ChunkWords);

      if ((abort_at > 0) && (sent == abort_at)) break;
    end

    readout_ready = 1'b0;
    chunk_trigger = 1'b0;
    cmd_start     = 1'b0;
    if (abort_at > 0) return;

    checkOutput("done_toggle", {31'd0, done_seen}, 32'd1);
    checkOutput("words_accepted", sent, n);
    checkOutput("words_drained", got, n);
    checkOutput("model_queue_empty", exp_q.size(), 32'd0);
    checkOutput("ready_after_done", {31'd0, chunk_ready}, 32'd0);
`ifdef IMG_CHUNK_SUM_EN
    checkOutput("status_sum", status_sum, model_sum);
`else
    checkOutput("status_sum", status_sum, 32'd0);
`endif

    // Idle: offered words must never be triggered, done must not toggle again.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      readout_ready = 1'b1;
      readout_data  = 16'($urandom);
      checkOutput("idle_trigger", {31'd0, readout_trigger}, 32'd0);
    end
    readout_ready = 1'b0;
    checkOutput("done_stable", {31'd0, status_done}, {31'd0, ~done_before});
  endtask

  initial begin
    rst           = 1'b1;
    cmd_start     = 1'b0;
    cmd_wordCount = 23'd0;
    readout_ready = 1'b0;
    readout_data  = 16'd0;
    chunk_trigger = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_readout_trigger", {31'd0, readout_trigger}, 32'd0);
    checkOutput("reset_chunk_ready", {31'd0, chunk_ready}, 32'd0);
    checkOutput("reset_chunk_last", {31'd0, chunk_last}, 32'd0);
    checkOutput("reset_chunk_len", {23'd0, chunk_len}, 32'd0);
    checkOutput("reset_status_done", {31'd0, status_done}, 32'd0);
    checkOutput("reset_status_sum", status_sum, 32'd0);
    rst = 1'b0;

    $display("[TB] two full chunks, trigger held");
    applyStimulus(512, 0, 100, 100, 0, 0, 1'b0);
    $display("[TB] 300 words: full chunk plus 44-word tail");
    applyStimulus(300, 2, 100, 100, 0, 0, 1'b0);
    $display("[TB] backpressure: 600 words, consumer stalled 1000 cycles");
    applyStimulus(600, 0, 100, 100, 1000, 0, 1'b0);
    $display("[TB] random handshakes, descending pattern, stray cmd_start");
    applyStimulus(1000, 1, 50, 50, 0, 0, 1'b1);
    $display("[TB] boundary lengths 0, 1, 257, 256");
    applyStimulus(0, 2, 100, 100, 0, 0, 1'b0);
    applyStimulus(1, 2, 70, 70, 0, 0, 1'b0);
    applyStimulus(257, 2, 60, 40, 0, 0, 1'b0);
    applyStimulus(256, 2, 80, 90, 0, 0, 1'b1);

    $display("[TB] reset mid-stream");
    applyStimulus(600, 2, 100, 0, 5000, 300, 1'b0);
    checkOutput("pre_reset_chunk_ready", {31'd0, chunk_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_chunk_ready", {31'd0, chunk_ready}, 32'd0);
    checkOutput("midrst_readout_trigger", {31'd0, readout_trigger}, 32'd0);
    checkOutput("midrst_chunk_len", {23'd0, chunk_len}, 32'd0);
    checkOutput("midrst_chunk_last", {31'd0, chunk_last}, 32'd0);
    checkOutput("midrst_status_done", {31'd0, status_done}, 32'd0);
    checkOutput("midrst_status_sum", status_sum, 32'd0);
    applyStimulus(16, 2, 80, 80, 0, 0, 1'b0);

    $display("[TB] word sum over 1..256");
    applyStimulus(256, 0, 100, 100, 0, 0, 1'b0);
`ifdef IMG_CHUNK_SUM_EN
    checkOutput("sum_1_to_256", status_sum, 32'd32896);
`else
    checkOutput("sum_disabled", status_sum, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
